// File: rtl/mul_sequencer.sv
// Multi-cycle 32x32 -> 64 multiplier sequencer (UMUL/SMUL, optional icc update).
// Operands are made positive through the shared ALU, multiplied by 32
// shift-and-add steps, and the 64-bit product is negated back when the
// operand signs differ. Latency from accepted start to done is always 37.
module mul_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              signed_op,
  input  logic              setcc,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_carry,
  output logic [5:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] y_out,
  output logic [DATA_W-1:0] rd_out,
  output logic              icc_we,
  output logic [3:0]        icc_nzvc
);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000100;
  localparam logic [5:0] OP_SUBX = 6'b001100;

  typedef enum logic [2:0] {
    S_IDLE, S_ABS1, S_ABS2, S_MUL, S_NEGLO, S_NEGHI, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_rs1;
  logic [DATA_W-1:0]   r_rs2;
  logic                r_signed;
  logic                r_setcc;
  logic [DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]   r_plo;
  logic [DATA_W-1:0]   r_phi;
  logic                r_neg;
  logic                r_borrow;
  logic [4:0]          r_cnt;
  logic [DATA_W-1:0]   r_y;
  logic [DATA_W-1:0]   r_rd;
  logic [3:0]          r_nzvc;
  logic                w_carry;

  // Carry out of the MUL-step add, derived from the ALU sum alone.
  assign w_carry = (alu_result < r_phi);

  assign y_out    = r_y;
  assign rd_out   = r_rd;
  assign icc_nzvc = r_nzvc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and per-state ALU/control outputs.
  always_comb begin
    w_next    = r_state;
    alu_a     = '0;
    alu_b     = '0;
    alu_carry = 1'b0;
    alu_op    = OP_ADD;
    busy      = (r_state != S_IDLE);
    done      = 1'b0;
    icc_we    = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ABS1;
      S_ABS1: begin
        alu_op = OP_SUB;
        alu_b  = r_rs1;
        w_next = S_ABS2;
      end
      S_ABS2: begin
        alu_op = OP_SUB;
        alu_b  = r_rs2;
        w_next = S_MUL;
      end
      S_MUL: begin
        alu_a = r_phi;
        alu_b = r_plo[0] ? r_mcand : '0;
        if (r_cnt == 5'd31) w_next = S_NEGLO;
      end
      S_NEGLO: begin
        if (r_neg) begin
          alu_op = OP_SUB;
          alu_b  = r_plo;
        end
        w_next = S_NEGHI;
      end
      S_NEGHI: begin
        if (r_neg) begin
          alu_op    = OP_SUBX;
          alu_b     = r_phi;
          alu_carry = r_borrow;
        end
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        icc_we = r_setcc;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch, absolute values, shift-add product and final negation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_signed <= 1'b0;
      r_setcc  <= 1'b0;
      r_mcand  <= '0;
      r_plo    <= '0;
      r_phi    <= '0;
      r_neg    <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_y      <= '0;
      r_rd     <= '0;
      r_nzvc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rs1    <= rs1;
            r_rs2    <= rs2;
            r_signed <= signed_op;
            r_setcc  <= setcc;
          end
        end
        S_ABS1: begin
          // 0x80000000 negates to itself, which read unsigned is 2^31.
          r_mcand <= (r_signed && r_rs1[DATA_W-1]) ? alu_result : r_rs1;
        end
        S_ABS2: begin
          r_plo <= (r_signed && r_rs2[DATA_W-1]) ? alu_result : r_rs2;
          r_phi <= '0;
          r_neg <= r_signed & (r_rs1[DATA_W-1] ^ r_rs2[DATA_W-1]);
          r_cnt <= '0;
        end
        S_MUL: begin
          r_phi <= {w_carry, alu_result[DATA_W-1:1]};
          r_plo <= {alu_result[0], r_plo[DATA_W-1:1]};
          r_cnt <= r_cnt + 5'd1;
        end
        S_NEGLO: begin
          if (r_neg) begin
            r_plo    <= alu_result;
            r_borrow <= (r_plo != '0);
          end else begin
            r_borrow <= 1'b0;
          end
        end
        S_NEGHI: begin
          // Results are registered here so they appear together with done.
          if (r_neg) begin
            r_phi <= alu_result;
            r_y   <= alu_result;
          end else begin
            r_y   <= r_phi;
          end
          r_rd <= r_plo;
          if (r_setcc) r_nzvc <= {r_plo[DATA_W-1], (r_plo == '0), 2'b00};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer with a behavioural shared ALU.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic        setcc = 1'b0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_carry;
  logic [5:0]  alu_op;
  logic        busy, done, icc_we;
  logic [31:0] y_out, rd_out;
  logic [3:0]  icc_nzvc;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    int          dcyc;
    logic [31:0] y;
    logic [31:0] rd;
    logic        we;
    logic [3:0]  nzvc;
  } exp_t;

  exp_t sb[$];

  mul_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .setcc(setcc), .rs1(rs1), .rs2(rs2), .alu_a(alu_a), .alu_b(alu_b),
    .alu_carry(alu_carry), .alu_op(alu_op), .alu_result(alu_result),
    .busy(busy), .done(done), .y_out(y_out), .rd_out(rd_out),
    .icc_we(icc_we), .icc_nzvc(icc_nzvc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU model: add, sub, subx.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      6'b000000: alu_result = alu_a + alu_b;
      6'b000100: alu_result = alu_a - alu_b;
      6'b001100: alu_result = alu_a - alu_b - {31'd0, alu_carry};
      default:   alu_result = '0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  logic        hold_pend = 1'b0;
  logic [31:0] hold_y, hold_rd;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (hold_pend) begin
        chk("y_hold", {32'd0, y_out}, {32'd0, hold_y});
        chk("rd_hold", {32'd0, rd_out}, {32'd0, hold_rd});
        hold_pend = 1'b0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("latency", 64'(cyc), 64'(e.dcyc));
          chk("y_out", {32'd0, y_out}, {32'd0, e.y});
          chk("rd_out", {32'd0, rd_out}, {32'd0, e.rd});
          chk("icc_we", {63'd0, icc_we}, {63'd0, e.we});
          chk("icc_nzvc", {60'd0, icc_nzvc}, {60'd0, e.nzvc});
          hold_y    = e.y;
          hold_rd   = e.rd;
          hold_pend = 1'b1;
        end
      end
    end
  end

  task automatic run_op(input logic sg, input logic sc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ey,
                        input logic [31:0] erd, input logic ewe,
                        input logic [3:0] enz, input logic eneg,
                        input logic extra);
    exp_t e;
    int   k;
    int   mulbad;
    int   busybad;
    wait_cycle();
    signed_op = sg; setcc = sc; rs1 = a; rs2 = b; start = 1'b1;
    k = cyc;
    e.dcyc = k + 37; e.y = ey; e.rd = erd; e.we = ewe; e.nzvc = enz;
    sb.push_back(e);
    mulbad  = 0;
    busybad = 0;
    for (int off = 1; off <= 38; off++) begin
      wait_cycle();
      start = extra && (off == 5 || off == 37);
      if (off >= 3 && off <= 34 && alu_op != 6'b000000) mulbad++;
      if (busy !== (off <= 37)) busybad++;
      if (off == 36 && eneg) chk("neghi_op", {58'd0, alu_op}, {58'd0, 6'b001100});
    end
    start = 1'b0;
    chk("mul_op", 64'(mulbad), 64'd0);
    chk("busy_window", 64'(busybad), 64'd0);
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_y", {32'd0, y_out}, 64'd0);
    chk("rst_rd", {32'd0, rd_out}, 64'd0);
    chk("rst_nzvc", {60'd0, icc_nzvc}, 64'd0);
    chk("rst_alu_op", {58'd0, alu_op}, 64'd0);
    wait_cycle(); wait_cycle();
    rst_n = 1'b1;
    wait_cycle();

    //      sg  sc  rs1           rs2           y             rd            we  nzvc     neg  extra
    run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 4'b0000, 1'b0, 1'b0);
    run_op(1'b1, 1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1, 4'b1000, 1'b1, 1'b0);
    run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 4'b1000, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 32'd0,        32'hFFFFFFF9, 32'h00000000, 32'h00000000, 1'b0, 4'b1000, 1'b1, 1'b0);
    run_op(1'b0, 1'b1, 32'd0,        32'h00001234, 32'h00000000, 32'h00000000, 1'b1, 4'b0100, 1'b0, 1'b1);
    run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 4'b0100, 1'b0, 1'b0);
    run_op(1'b1, 1'b1, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b1, 4'b1000, 1'b1, 1'b0);

    // Abort an operation with reset at k+10; no done may follow.
    wait_cycle();
    signed_op = 1'b0; setcc = 1'b1; rs1 = 32'd100; rs2 = 32'd3; start = 1'b1;
    wait_cycle();
    start = 1'b0;
    repeat (9) wait_cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_y", {32'd0, y_out}, 64'd0);
    chk("abort_rd", {32'd0, rd_out}, 64'd0);
    chk("abort_nzvc", {60'd0, icc_nzvc}, 64'd0);
    chk("abort_alu_a", {32'd0, alu_a}, 64'd0);
    wait_cycle(); wait_cycle();
    rst_n = 1'b1;
    repeat (45) wait_cycle();

    run_op(1'b0, 1'b0, 32'd6, 32'd7, 32'h00000000, 32'd42, 1'b0, 4'b0000, 1'b0, 1'b0);

    repeat (5) wait_cycle();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have one clock and one reset: clock clk, reset rst_n, asynchronous, active-low.
REQ-002 SHALL provide ports as follows:
  clk  in  1  clock, rising edge
  rst_n  in  1  async active-low reset
  start  in  1  request a multiply; sampled only in IDLE
  signed_op  in  1  1 = SMUL (two's complement), 0 = UMUL
  setcc  in  1  1 = update icc on completion (UMULcc/SMULcc)
  rs1  in  32  multiplicand
  rs2  in  32  multiplier
  alu_a  out  32  operand A driven to the shared ALU
  alu_b  out  32  operand B driven to the shared ALU
  alu_carry  out  1  carry-in driven to the ALU
  alu_op  out  6  ALU opcode
  alu_result  in  32  combinational ALU output, same cycle
  busy  out  1  operation in progress
  done  out  1  one-cycle completion pulse
  y_out  out  32  product bits 63:32 (Y register value)
  rd_out  out  32  product bits 31:0
  icc_we  out  1  icc write strobe, coincident with done
  icc_nzvc  out  4  {N,Z,V,C}

Function
REQ-003 SHALL latch rs1, rs2, signed_op and setcc on the edge where start=1 in IDLE.
REQ-004 SHALL implement states IDLE, ABS1, ABS2, MUL, NEGLO, NEGHI and DONE; IDLE->ABS1 on start; ABS1->ABS2->MUL; MUL for exactly 32 cycles; then ->NEGLO->NEGHI->DONE->IDLE.
REQ-005 SHALL have fixed latency: start accepted in cycle k gives done=1 in cycle k+37, independent of operand values and signedness.
REQ-006 SHALL hold busy=1 from cycle k+1 through k+37 inclusive; start SHALL be ignored in every state except IDLE.
REQ-007 ABS1: alu_op=6'b000100 (sub), alu_a=0, alu_b=rs1; multiplicand register <= alu_result if signed_op and rs1[31], else rs1.
REQ-008 ABS2: same as ABS1 applied to rs2, written into the low product register P_lo; P_hi <= 0; negate flag <= signed_op & (rs1[31]^rs2[31]).
REQ-009 MUL: alu_op=6'b000000 (add), alu_a=P_hi, alu_b = P_lo[0] ? multiplicand : 0; carry-out c = (alu_result < alu_a, unsigned); {P_hi,P_lo} <= {c, alu_result, P_lo[31:1]}.
REQ-010 SHALL compute carry/borrow internally and SHALL NOT depend on ALU flag outputs.
REQ-011 NEGLO (negate flag set): alu_op=sub, alu_a=0, alu_b=P_lo; P_lo <= alu_result; borrow register <= (P_lo != 0). If the negate flag is clear, SHALL hold P_lo and clear borrow.
REQ-012 NEGHI (negate flag set): alu_op=6'b001100 (subx), alu_a=0, alu_b=P_hi, alu_carry=borrow; P_hi <= alu_result. If the negate flag is clear, SHALL hold P_hi.
REQ-013 In all other states, alu_a, alu_b and alu_carry SHALL be 0 and alu_op SHALL be 6'b000000.
REQ-014 DONE: done=1; y_out <= P_hi and rd_out <= P_lo become visible in the same cycle as done and SHALL be held until the next DONE.
REQ-015 DONE with latched setcc=1: icc_we=1; icc_nzvc = {rd_out[31], rd_out==0, 0, 0}; icc_nzvc SHALL be held otherwise. With setcc=0, icc_we SHALL stay 0.
REQ-016 Magnitude 0x80000000 SHALL be treated as unsigned 2^31, so that -2^31 operands produce correct products.

Reset
REQ-017 rst_n=0 SHALL immediately force IDLE and set busy, done, icc_we, y_out, rd_out, icc_nzvc, alu_a, alu_b, alu_carry and alu_op to 0, and clear all internal registers.
REQ-018 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification
REQ-019 UMUL 0xFFFFFFFF x 0xFFFFFFFF, start in cycle k -> done in k+37, y_out=0xFFFFFFFE, rd_out=0x00000001, icc_we=0.
REQ-020 SMULcc -3 x 5 -> y_out=0xFFFFFFFF, rd_out=0xFFFFFFF1, icc_we=1, icc_nzvc=4'b1000.
REQ-021 SMUL 0x80000000 x 0x80000000 -> y_out=0x40000000, rd_out=0x00000000; SMUL 0 x -7 -> both words 0.
REQ-022 UMULcc 0 x 0x1234 -> rd_out=0, icc_nzvc=4'b0100; start pulses at k+5 and k+37 -> ignored, exactly one done.
REQ-023 rst_n low at cycle k+10 -> busy=0 and outputs 0 asynchronously, no done; new UMUL 6 x 7 -> rd_out=42 at +37 cycles.
REQ-024 Every MUL-state cycle -> alu_op=6'b000000; NEGHI with negate set -> alu_op=6'b001100.
